// File: rtl/e203_ifu_bpu_rs1_rdctl_pkg.sv
// ---------------------------------------------------------------------------
// e203_ifu_bpu_rs1_rdctl_pkg
//
// Shared definitions for the BPU rs1 read controller:
//   - default widths for PC, register data and register index
//   - default starvation limit (lost arbitration cycles before the BPU
//     takes priority over the EXU on read port 1)
//   - state encoding of the read sequencer
//   - hazard_ok(): the RAW-hazard clearance rule against OITF and IR
// ---------------------------------------------------------------------------
package e203_ifu_bpu_rs1_rdctl_pkg;

    localparam int E203_PC_SIZE        = 32;
    localparam int E203_XLEN           = 32;
    localparam int E203_RFIDX_WIDTH    = 5;
    localparam int E203_BPURD_MAX_WAIT = 7;

    // Width of the starvation counter; MAX_WAIT must fit (1..15).
    localparam int STARV_CNT_W = 4;

    typedef enum logic [2:0] {
        BPURD_IDLE = 3'd0,
        BPURD_DEP  = 3'd1,
        BPURD_ARB  = 3'd2,
        BPURD_READ = 3'd3,
        BPURD_RESP = 3'd4
    } bpurd_state_e;

    // The jalr rs1 can be read once no older instruction can still write it:
    // either OITF and IR are both empty, or OITF is empty and the IR
    // instruction is leaving this cycle or does not use read port 1.
    function automatic logic hazard_ok(input logic oitf_empty,
                                       input logic ir_empty,
                                       input logic ir_valid_clr,
                                       input logic ir_rs1en);
        logic dep;
        logic early_clr;
        dep       = ~oitf_empty | ~ir_empty;
        early_clr = oitf_empty & ~ir_empty & (ir_valid_clr | ~ir_rs1en);
        return ~dep | early_clr;
    endfunction

endpackage

// File: rtl/e203_ifu_bpu_rs1_rdctl_if.sv
// ---------------------------------------------------------------------------
// e203_ifu_bpu_rs1_rdctl_if
//
// Request/response bundle between the IFU branch predictor (master) and the
// rs1 read controller (slave).
//   jalr_req      master->slave  level request, held until jalr_rs1_vld
//   jalr_rs1idx   master->slave  rs1 index of the requesting jalr
//   bpu_wait      slave->master  stall next-PC generation
//   jalr_rs1_vld  slave->master  one-cycle pulse, jalr_rs1_val valid
//   jalr_rs1_val  slave->master  captured rs1 value
// ---------------------------------------------------------------------------
interface e203_ifu_bpu_rs1_rdctl_if
    import e203_ifu_bpu_rs1_rdctl_pkg::*;
#(
    parameter int RFIDX_W = E203_RFIDX_WIDTH,
    parameter int XLEN    = E203_XLEN
) ();

    logic               jalr_req;
    logic [RFIDX_W-1:0] jalr_rs1idx;
    logic               bpu_wait;
    logic               jalr_rs1_vld;
    logic [XLEN-1:0]    jalr_rs1_val;

    modport master (
        output jalr_req,
        output jalr_rs1idx,
        input  bpu_wait,
        input  jalr_rs1_vld,
        input  jalr_rs1_val
    );

    modport slave (
        input  jalr_req,
        input  jalr_rs1idx,
        output bpu_wait,
        output jalr_rs1_vld,
        output jalr_rs1_val
    );

endinterface

// File: rtl/e203_ifu_bpu_rs1_starv_cnt.sv
// ---------------------------------------------------------------------------
// e203_ifu_bpu_rs1_starv_cnt
//
// Saturating 4-bit counter of arbitration cycles the BPU has lost.
//   clk, rst_n  clock, asynchronous active-low reset
//   inc         count one lost cycle (ignored once saturated)
//   clr         return to zero; wins over inc
//   sat         counter has reached MAX_WAIT
// ---------------------------------------------------------------------------
module e203_ifu_bpu_rs1_starv_cnt
    import e203_ifu_bpu_rs1_rdctl_pkg::*;
#(
    parameter int MAX_WAIT = E203_BPURD_MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [STARV_CNT_W-1:0] MAX_VAL = STARV_CNT_W'(MAX_WAIT);

    logic [STARV_CNT_W-1:0] cnt;

    assign sat = (cnt == MAX_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/e203_ifu_bpu_rs1_rdctl.sv
// ---------------------------------------------------------------------------
// e203_ifu_bpu_rs1_rdctl
//
// Reads rs1 of a jalr (rs1 = xn) on behalf of the IFU branch predictor.
// Waits out RAW hazards against OITF and the IR stage, arbitrates register
// file read port 1 against the EXU decode read, captures the value and
// returns it with a one-cycle valid pulse.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bpu            BPU request/response bundle (slave side)
//   oitf_empty     OITF holds no long-pipe instructions
//   ir_empty       IR stage empty
//   ir_valid_clr   IR instruction leaves this cycle
//   ir_rs1en       IR instruction uses read port 1
//   flush          pipeline flush, aborts any transaction
//   exu_rd_req     EXU wants port 1 this cycle
//   exu_rd_idx     EXU rs1 index
//   exu_rd_gnt     EXU granted port 1
//   rf_rs1_ena     load enable for the rs1 index register
//   rf_rs1_idx     index loaded into the rs1 index register
//   rf_rs1_data    port 1 read data, valid the cycle after rf_rs1_ena
// ---------------------------------------------------------------------------
module e203_ifu_bpu_rs1_rdctl
    import e203_ifu_bpu_rs1_rdctl_pkg::*;
#(
    parameter int PC_SIZE  = E203_PC_SIZE,
    parameter int XLEN     = E203_XLEN,
    parameter int RFIDX_W  = E203_RFIDX_WIDTH,
    parameter int MAX_WAIT = E203_BPURD_MAX_WAIT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    e203_ifu_bpu_rs1_rdctl_if.slave bpu,
    input  logic                    oitf_empty,
    input  logic                    ir_empty,
    input  logic                    ir_valid_clr,
    input  logic                    ir_rs1en,
    input  logic                    flush,
    input  logic                    exu_rd_req,
    input  logic [RFIDX_W-1:0]      exu_rd_idx,
    output logic                    exu_rd_gnt,
    output logic                    rf_rs1_ena,
    output logic [RFIDX_W-1:0]      rf_rs1_idx,
    input  logic [XLEN-1:0]         rf_rs1_data
);

    // PC_SIZE only keeps this block's parameter list aligned with the rest
    // of the IFU; no PC passes through here. An out-of-range parameter set
    // shows up as this named block in the elaborated hierarchy.
    if (PC_SIZE < 1 || MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_param_out_of_range
    end

    bpurd_state_e       state;
    bpurd_state_e       state_nxt;
    logic [RFIDX_W-1:0] idx_q;
    logic [XLEN-1:0]    val_q;
    logic               vld_q;

    logic st_idle;
    logic st_dep;
    logic st_arb;
    logic st_read;
    logic haz_ok;
    logic req_live;
    logic want;
    logic bpu_win;
    logic starve_sat;
    logic cnt_inc;
    logic cnt_clr;

    assign st_idle = (state == BPURD_IDLE);
    assign st_dep  = (state == BPURD_DEP);
    assign st_arb  = (state == BPURD_ARB);
    assign st_read = (state == BPURD_READ);

    assign haz_ok   = hazard_ok(oitf_empty, ir_empty, ir_valid_clr, ir_rs1en);
    assign req_live = st_idle & bpu.jalr_req & ~flush;

    // The BPU asks for the port straight from IDLE when nothing blocks it,
    // otherwise from ARB. It yields to the EXU until it has lost MAX_WAIT
    // cycles in ARB, after which it takes the port regardless.
    assign want    = (req_live & haz_ok) | (st_arb & ~flush);
    assign bpu_win = want & (~exu_rd_req | starve_sat);

    assign exu_rd_gnt = exu_rd_req & ~bpu_win;
    assign rf_rs1_ena = bpu_win | exu_rd_gnt;
    assign rf_rs1_idx = bpu_win ? (st_idle ? bpu.jalr_rs1idx : idx_q) : exu_rd_idx;

    assign bpu.bpu_wait     = req_live | st_dep | st_arb | st_read;
    assign bpu.jalr_rs1_vld = vld_q;
    assign bpu.jalr_rs1_val = val_q;

    assign cnt_inc = st_arb & ~bpu_win;
    assign cnt_clr = bpu_win | st_idle | flush;

    e203_ifu_bpu_rs1_starv_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .sat   (starve_sat)
    );

    // Next-state decode. A flush from any state returns to IDLE, which also
    // drops any read already in flight so no valid pulse follows it.
    always_comb begin
        state_nxt = state;
        case (state)
            BPURD_IDLE: begin
                if (req_live) begin
                    if (!haz_ok) begin
                        state_nxt = BPURD_DEP;
                    end else if (bpu_win) begin
                        state_nxt = BPURD_READ;
                    end else begin
                        state_nxt = BPURD_ARB;
                    end
                end
            end
            BPURD_DEP: begin
                if (haz_ok) begin
                    state_nxt = BPURD_ARB;
                end
            end
            BPURD_ARB: begin
                if (bpu_win) begin
                    state_nxt = BPURD_READ;
                end
            end
            BPURD_READ: state_nxt = BPURD_RESP;
            BPURD_RESP: state_nxt = BPURD_IDLE;
            default:    state_nxt = BPURD_IDLE;
        endcase
        if (flush) begin
            state_nxt = BPURD_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BPURD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The request index is only guaranteed on the IDLE cycle that accepts
    // it, so it is kept for a later win out of ARB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (req_live) begin
            idx_q <= bpu.jalr_rs1idx;
        end
    end

    // Read data arrives in the cycle after the index was loaded (READ);
    // capture it there and raise valid for exactly the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= st_read & ~flush;
            if (st_read && !flush) begin
                val_q <= rf_rs1_data;
            end
        end
    end

endmodule

// File: tb/tb_e203_ifu_bpu_rs1_rdctl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_e203_ifu_bpu_rs1_rdctl
//
// Scoreboarded bench: the driver applies one cycle of inputs, asks a
// transaction-level reference model what the block must show that cycle and
// queues it; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_e203_ifu_bpu_rs1_rdctl;

    localparam int XLEN     = 32;
    localparam int RFIDX_W  = 5;
    localparam int MAX_WAIT = 7;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               oitf_empty = 1'b0;
    logic               ir_empty = 1'b0;
    logic               ir_valid_clr = 1'b0;
    logic               ir_rs1en = 1'b0;
    logic               flush = 1'b0;
    logic               exu_rd_req = 1'b0;
    logic [RFIDX_W-1:0] exu_rd_idx = '0;
    logic               exu_rd_gnt;
    logic               rf_rs1_ena;
    logic [RFIDX_W-1:0] rf_rs1_idx;
    logic [XLEN-1:0]    rf_rs1_data = '0;

    e203_ifu_bpu_rs1_rdctl_if #(.RFIDX_W(RFIDX_W), .XLEN(XLEN)) bpu_if ();

    e203_ifu_bpu_rs1_rdctl #(
        .PC_SIZE  (32),
        .XLEN     (XLEN),
        .RFIDX_W  (RFIDX_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bpu          (bpu_if),
        .oitf_empty   (oitf_empty),
        .ir_empty     (ir_empty),
        .ir_valid_clr (ir_valid_clr),
        .ir_rs1en     (ir_rs1en),
        .flush        (flush),
        .exu_rd_req   (exu_rd_req),
        .exu_rd_idx   (exu_rd_idx),
        .exu_rd_gnt   (exu_rd_gnt),
        .rf_rs1_ena   (rf_rs1_ena),
        .rf_rs1_idx   (rf_rs1_idx),
        .rf_rs1_data  (rf_rs1_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               req;
        logic [RFIDX_W-1:0] idx;
        logic               oitf_empty;
        logic               ir_empty;
        logic               ir_valid_clr;
        logic               ir_rs1en;
        logic               flush;
        logic               exu_req;
        logic [RFIDX_W-1:0] exu_idx;
        logic [XLEN-1:0]    data;
    } stim_t;

    typedef struct {
        logic               gnt;
        logic               ena;
        logic [RFIDX_W-1:0] rf_idx;
        logic               bwait;
        logic               vld;
        logic [XLEN-1:0]    val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model: where the outstanding jalr read stands.
    bit                 m_wait_haz;
    bit                 m_wait_port;
    bit                 m_data_due;
    bit                 m_resp;
    int                 m_losses;
    logic [RFIDX_W-1:0] m_idx;
    logic [XLEN-1:0]    m_val;

    // Requester bookkeeping for random traffic.
    bit                 req_hold;
    logic [RFIDX_W-1:0] req_idx;
    bit                 flushed_last;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_wait_haz   = 0;
        m_wait_port  = 0;
        m_data_due   = 0;
        m_resp       = 0;
        m_losses     = 0;
        m_idx        = '0;
        m_val        = '0;
        req_hold     = 0;
        flushed_last = 0;
    endtask

    function automatic bit modelIdle();
        return !(m_wait_haz || m_wait_port || m_data_due || m_resp);
    endfunction

    function automatic stim_t quietStim();
        stim_t s;
        s.req          = 1'b0;
        s.idx          = '0;
        s.oitf_empty   = 1'b1;
        s.ir_empty     = 1'b1;
        s.ir_valid_clr = 1'b0;
        s.ir_rs1en     = 1'b0;
        s.flush        = 1'b0;
        s.exu_req      = 1'b0;
        s.exu_idx      = '0;
        s.data         = $urandom;
        return s;
    endfunction

    // Drive one cycle, predict what the block shows during it, advance model.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   idle, fresh, ok, try_port, win, nh, np, nd, nr;
        @(posedge clk);
        #1;
        bpu_if.jalr_req    = s.req;
        bpu_if.jalr_rs1idx = s.idx;
        oitf_empty         = s.oitf_empty;
        ir_empty           = s.ir_empty;
        ir_valid_clr       = s.ir_valid_clr;
        ir_rs1en           = s.ir_rs1en;
        flush              = s.flush;
        exu_rd_req         = s.exu_req;
        exu_rd_idx         = s.exu_idx;
        rf_rs1_data        = s.data;

        idle     = modelIdle();
        ok       = s.oitf_empty && (s.ir_empty || s.ir_valid_clr || !s.ir_rs1en);
        fresh    = idle && s.req && !s.flush;
        try_port = (fresh && ok) || (m_wait_port && !s.flush);
        win      = try_port && (!s.exu_req || m_losses >= MAX_WAIT);

        e.gnt    = s.exu_req && !win;
        e.ena    = win || e.gnt;
        e.rf_idx = !win ? s.exu_idx : (fresh ? s.idx : m_idx);
        e.bwait  = fresh || m_wait_haz || m_wait_port || m_data_due;
        e.vld    = m_resp;
        e.val    = m_val;
        sb.push_back(e);

        if (fresh) m_idx = s.idx;
        if (s.flush || idle || win) m_losses = 0;
        else if (m_wait_port && m_losses < MAX_WAIT) m_losses++;

        if (s.flush) begin
            m_wait_haz  = 0;
            m_wait_port = 0;
            m_data_due  = 0;
            m_resp      = 0;
        end else begin
            if (m_data_due) m_val = s.data;
            nh = (fresh || m_wait_haz) && !ok;
            np = (fresh && ok && !win) || (m_wait_haz && ok) || (m_wait_port && !win);
            nd = win;
            nr = m_data_due;
            m_wait_haz  = nh;
            m_wait_port = np;
            m_data_due  = nd;
            m_resp      = nr;
        end
    endtask

    // mode 0: mixed traffic, 1: EXU hogging the port, 2: frequent hazards
    task automatic randomCycle(input int mode);
        stim_t s;
        s = quietStim();
        s.flush        = ($urandom_range(0, 39) == 0);
        s.oitf_empty   = (mode == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) != 0);
        s.ir_empty     = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        s.ir_valid_clr = 1'($urandom_range(0, 1));
        s.ir_rs1en     = 1'($urandom_range(0, 1));
        s.exu_req      = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
        s.exu_idx      = RFIDX_W'($urandom);
        if (req_hold && (m_resp || flushed_last)) req_hold = 0;
        if (!req_hold && modelIdle() && $urandom_range(0, 3) == 0) begin
            req_hold = 1;
            req_idx  = RFIDX_W'($urandom);
        end
        s.req        = req_hold;
        s.idx        = req_idx;
        flushed_last = s.flush;
        applyStimulus(s);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("exu_rd_gnt", 32'(exu_rd_gnt), 32'(e.gnt));
            checkOutput("rf_rs1_ena", 32'(rf_rs1_ena), 32'(e.ena));
            checkOutput("rf_rs1_idx", 32'(rf_rs1_idx), 32'(e.rf_idx));
            checkOutput("bpu_wait", 32'(bpu_if.bpu_wait), 32'(e.bwait));
            checkOutput("jalr_rs1_vld", 32'(bpu_if.jalr_rs1_vld), 32'(e.vld));
            checkOutput("jalr_rs1_val", bpu_if.jalr_rs1_val, e.val);
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " vld"}, 32'(bpu_if.jalr_rs1_vld), 32'd0);
        checkOutput({tag, " bpu_wait"}, 32'(bpu_if.bpu_wait), 32'd0);
        checkOutput({tag, " val"}, bpu_if.jalr_rs1_val, 32'd0);
        checkOutput({tag, " ena"}, 32'(rf_rs1_ena), 32'd0);
        checkOutput({tag, " gnt"}, 32'(exu_rd_gnt), 32'd0);
    endtask

    initial begin : driver
        stim_t s;
        int    mode;
        bpu_if.jalr_req    = 1'b0;
        bpu_if.jalr_rs1idx = '0;
        modelReset();

        #3;
        checkResetOutputs("reset");
        #9 rst_n = 1'b1;

        // Fast path: idx 5, data captured in the READ cycle.
        s = quietStim(); s.req = 1; s.idx = 5'd5;
        applyStimulus(s);
        s.data = 32'h8000_1234;
        applyStimulus(s);
        s = quietStim();
        applyStimulus(s);
        applyStimulus(quietStim());

        // Hazard: OITF busy for four cycles, then clear.
        s = quietStim(); s.req = 1; s.idx = 5'd9; s.oitf_empty = 0;
        for (int i = 0; i < 4; i++) applyStimulus(s);
        s.oitf_empty = 1;
        for (int i = 0; i < 3; i++) begin s.data = $urandom; applyStimulus(s); end
        applyStimulus(quietStim());
        applyStimulus(quietStim());

        // Early clear: IR instruction leaving in the request cycle.
        s = quietStim(); s.req = 1; s.idx = 5'd17; s.ir_empty = 0; s.ir_valid_clr = 1; s.ir_rs1en = 1;
        applyStimulus(s);
        s = quietStim(); s.req = 1; s.idx = 5'd17;
        applyStimulus(s);
        applyStimulus(quietStim());
        applyStimulus(quietStim());

        // Starvation: EXU requests every cycle; the BPU wins after MAX_WAIT.
        s = quietStim(); s.req = 1; s.idx = 5'd12; s.exu_req = 1; s.exu_idx = 5'd3;
        for (int i = 0; i < MAX_WAIT + 3; i++) begin s.data = $urandom; applyStimulus(s); end
        s.req = 0;
        applyStimulus(s);
        applyStimulus(quietStim());

        // Flush during READ, then a clean request.
        s = quietStim(); s.req = 1; s.idx = 5'd7;
        applyStimulus(s);
        s.flush = 1;
        applyStimulus(s);
        applyStimulus(quietStim());
        s = quietStim(); s.req = 1; s.idx = 5'd21;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(quietStim());
        applyStimulus(quietStim());

        // Randomised traffic.
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) mode = $urandom_range(0, 2);
            randomCycle(mode);
        end

        // Asynchronous reset while waiting in ARB.
        for (int c = 0; c < 500 && !m_wait_port; c++) randomCycle(1);
        @(posedge clk);
        #1;
        bpu_if.jalr_req = 1'b0;
        exu_rd_req      = 1'b0;
        flush           = 1'b0;
        rst_n           = 1'b0;
        #1;
        checkResetOutputs("async reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        modelReset();

        for (int c = 0; c < 300; c++) randomCycle($urandom_range(0, 2));

        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/e203_ifu_bpu_rs1_rdctl.md
Name: e203_ifu_bpu_rs1_rdctl

Overview:
- Sequencer and arbiter for register-file read port 1 when the IFU branch predictor needs rs1 of a jalr whose rs1 is xn (neither x0 nor x1).
- Waits out RAW hazards against OITF and the IR stage, then arbitrates port 1 against the EXU decode read.
- Captures the register value and returns it to the BPU with a one-cycle valid pulse.
- Sits between the IFU mini-decode/BPU and the regfile rs1 index register in the IR stage.

Parameters:
- PC_SIZE, 32, PC width (`E203_PC_SIZE).
- XLEN, 32, register data width (`E203_XLEN).
- RFIDX_W, 5, register index width (`E203_RFIDX_WIDTH).
- MAX_WAIT, 7, number of lost arbitration cycles after which the BPU gets priority over the EXU (1..15).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- jalr_req  in  1  jalr-xn read request; level; held until jalr_rs1_vld
- jalr_rs1idx  in  RFIDX_W  rs1 index of the requesting jalr
- oitf_empty  in  1  OITF holds no long-pipe instructions
- ir_empty  in  1  IR stage empty
- ir_valid_clr  in  1  IR instruction leaves this cycle
- ir_rs1en  in  1  IR instruction uses read port 1
- flush  in  1  pipeline flush; aborts any transaction
- exu_rd_req  in  1  EXU wants port 1 this cycle
- exu_rd_idx  in  RFIDX_W  EXU rs1 index
- exu_rd_gnt  out  1  EXU granted port 1
- rf_rs1_ena  out  1  load enable for the rs1 index register
- rf_rs1_idx  out  RFIDX_W  index loaded into the rs1 index register
- rf_rs1_data  in  XLEN  port 1 read data, valid the cycle after rf_rs1_ena
- bpu_wait  out  1  stall IFU next-PC generation
- jalr_rs1_vld  out  1  one-cycle pulse; jalr_rs1_val valid
- jalr_rs1_val  out  XLEN  captured rs1 value

Behaviour:
- The clock and reset are fixed: one clock (clk); reset (rst_n) is asynchronous and active-low.
- States: IDLE, DEP, ARB, READ, RESP; all state is registered with sirv_gnrl_dfflr/dffr.
- Reset values: state=IDLE, latched idx=0, jalr_rs1_val=0, jalr_rs1_vld=0, starve_cnt=0. With all inputs 0, every combinational output is 0.
- Hazard terms:
  - dep = ~oitf_empty | ~ir_empty.
  - early_clr = oitf_empty & ~ir_empty & (ir_valid_clr | ~ir_rs1en).
  - haz_ok = ~dep | early_clr.
- BPU arbitration win: bpu_win = want & (~exu_rd_req | starve_cnt==MAX_WAIT), where want = (IDLE & jalr_req & haz_ok & ~flush) | (ARB & ~flush).
- Port 1 drive:
  - exu_rd_gnt = exu_rd_req & ~bpu_win.
  - rf_rs1_ena = bpu_win | exu_rd_gnt.
  - rf_rs1_idx = bpu_win ? (IDLE ? jalr_rs1idx : latched idx) : exu_rd_idx.
- Index latch: loaded from jalr_rs1idx on any IDLE cycle with jalr_req & ~flush.
- IDLE transitions, when jalr_req & ~flush:
  - ~haz_ok -> DEP.
  - haz_ok & bpu_win -> READ.
  - haz_ok & ~bpu_win -> ARB.
- DEP: haz_ok -> ARB, else stay. There is no port request in DEP.
- ARB: bpu_win -> READ, else stay.
- starve_cnt increments in every ARB cycle with ~bpu_win, saturating at MAX_WAIT. It clears on bpu_win, in IDLE, and on flush.
- READ: jalr_rs1_val <= rf_rs1_data; next state RESP.
- RESP: jalr_rs1_vld=1 (registered); next state IDLE. jalr_req is ignored in RESP. The requester must drop jalr_req in the RESP cycle.
- bpu_wait = (IDLE & jalr_req & ~flush) | DEP | ARB | READ. It is low in RESP.
- flush, in any state: next state IDLE, no vld pulse, data from an in-flight READ is discarded, starve_cnt cleared. An EXU request is still granted in a flush cycle.
- Best-case latency: req at cycle 0 (hazard clear, EXU idle) -> ena at cycle 0, READ at cycle 1, vld at cycle 2.
- jalr_rs1idx of 0 or 1 is a caller error; the block performs the read anyway with no special casing.

Decomposition:
- State encodings (3-bit, IDLE=0, DEP=1, ARB=2, READ=3, RESP=4) go in e203_defines.v as `E203_BPURD_ST_*.
- MAX_WAIT default goes in e203_defines.v.
- One sub-module, e203_ifu_bpu_rs1_starv_cnt: saturating 4-bit counter with inc/clr/sat output, instanced once.

Test Plan:
- Reset mid-ARB: assert rst_n=0 -> state IDLE, vld=0, bpu_wait=0, val=0 asynchronously.
- Fast path: oitf_empty=1, ir_empty=1, exu_rd_req=0, jalr_req with idx=5 -> cycle 0: ena=1, idx=5, bpu_wait=1. Drive rf_rs1_data=0x8000_1234 in cycle 1 -> cycle 2: vld=1, val=0x8000_1234, bpu_wait=0.
- Hazard: oitf_empty=0 for 4 cycles -> state DEP, bpu_wait=1, no ena. Then oitf_empty=1, ir_empty=1 -> ARB -> READ -> vld 3 cycles after the hazard clears (exu idle).
- Early clear: oitf_empty=1, ir_empty=0, ir_valid_clr=1 at req -> ena in the same cycle, no DEP visit.
- Starvation: exu_rd_req=1 constantly while in ARB -> exu_rd_gnt=1 for 7 cycles. In cycle 8, bpu_win=1, exu_rd_gnt=0, idx=latched BPU idx.
- Flush in READ -> next cycle IDLE, no vld pulse, bpu_wait=0. A new req afterwards completes normally.
